// File: rtl/core_boot_loader.sv
// Byte-stream packet decoder feeding s_core's setup port: loads instruction memory and
// register file, then releases the core from setup mode on START until a HALT byte.
module core_boot_loader #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_rx_ready,
    output logic [31:0]      o_inst_mem_addr,
    output logic [31:0]      o_inst_mem_data,
    output logic             o_inst_mem_we,
    output logic [4:0]       o_load_reg_addr,
    output logic [31:0]      o_load_reg_data,
    output logic             o_load_reg_we,
    output logic [31:0]      o_pc_instr_start_addr,
    output logic             o_setup,
    output logic [CNT_W-1:0] o_inst_count,
    output logic             o_err
);

    localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_COMMIT,
        S_RUN
    } state_t;

    typedef enum logic [1:0] {
        C_INST,
        C_REG,
        C_START
    } cmd_t;

    state_t            state;
    cmd_t              cmd;
    logic [1:0]        byte_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [31:0]       addr_sr;
    logic [23:0]       data_sr;
    logic [4:0]        reg_idx;
    logic              accept;

    assign o_rx_ready = (state != S_COMMIT);
    assign accept     = i_rx_valid && o_rx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                 <= S_IDLE;
            cmd                   <= C_INST;
            byte_cnt              <= '0;
            gap_cnt               <= '0;
            addr_sr               <= '0;
            data_sr               <= '0;
            reg_idx               <= '0;
            o_inst_mem_addr       <= '0;
            o_inst_mem_data       <= '0;
            o_inst_mem_we         <= 1'b0;
            o_load_reg_addr       <= '0;
            o_load_reg_data       <= '0;
            o_load_reg_we         <= 1'b0;
            o_pc_instr_start_addr <= '0;
            o_setup               <= 1'b1;
            o_inst_count          <= '0;
            o_err                 <= 1'b0;
        end else begin
            o_inst_mem_we <= 1'b0;
            o_load_reg_we <= 1'b0;

            // Inter-byte watchdog: a byte in the final idle cycle still counts as on time.
            if (state == S_ADDR || state == S_DATA) begin
                if (accept) begin
                    gap_cnt <= '0;
                end else if (gap_cnt == GAP_LAST) begin
                    gap_cnt  <= '0;
                    byte_cnt <= '0;
                    o_err    <= 1'b1;
                    state    <= S_IDLE;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        byte_cnt <= '0;
                        gap_cnt  <= '0;
                        case (i_rx_data)
                            8'h01: begin
                                cmd   <= C_INST;
                                state <= S_ADDR;
                            end
                            8'h02: begin
                                cmd   <= C_REG;
                                state <= S_ADDR;
                            end
                            8'h03: begin
                                cmd   <= C_START;
                                state <= S_ADDR;
                            end
                            default: o_err <= 1'b1;
                        endcase
                    end
                end

                S_ADDR: begin
                    if (accept) begin
                        addr_sr  <= {i_rx_data, addr_sr[31:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (cmd == C_REG) begin
                            reg_idx  <= i_rx_data[4:0];
                            byte_cnt <= '0;
                            state    <= S_DATA;
                        end else if (byte_cnt == 2'd3) begin
                            byte_cnt <= '0;
                            if (cmd == C_START) begin
                                o_pc_instr_start_addr <= {i_rx_data, addr_sr[31:8]};
                                o_setup               <= 1'b0;
                                state                 <= S_COMMIT;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (accept) begin
                        data_sr  <= {i_rx_data, data_sr[23:8]};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            byte_cnt <= '0;
                            state    <= S_COMMIT;
                            if (cmd == C_INST) begin
                                o_inst_mem_addr <= addr_sr;
                                o_inst_mem_data <= {i_rx_data, data_sr};
                                o_inst_mem_we   <= 1'b1;
                                if (o_inst_count != '1) begin
                                    o_inst_count <= o_inst_count + 1'b1;
                                end
                            end else if (reg_idx != '0) begin
                                // x0 is hardwired in the core, so its writes are silently dropped.
                                o_load_reg_addr <= reg_idx;
                                o_load_reg_data <= {i_rx_data, data_sr};
                                o_load_reg_we   <= 1'b1;
                            end
                        end
                    end
                end

                S_COMMIT: begin
                    state <= (cmd == C_START) ? S_RUN : S_IDLE;
                end

                S_RUN: begin
                    if (accept && i_rx_data == 8'h04) begin
                        o_setup <= 1'b1;
                        state   <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_boot_loader.sv
// Randomized scoreboard bench for core_boot_loader: packet-level reference model pushes
// expected write/start/halt events, a negedge monitor pops them as the DUT produces them.
module tb_core_boot_loader;

    localparam int T   = 16;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [31:0]   inst_addr;
    logic [31:0]   inst_data;
    logic          inst_we;
    logic [4:0]    reg_addr;
    logic [31:0]   reg_data;
    logic          reg_we;
    logic [31:0]   start_pc;
    logic          setup;
    logic [CW-1:0] inst_count;
    logic          err;

    core_boot_loader #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .i_rx_data             (rx_data),
        .i_rx_valid            (rx_valid),
        .o_rx_ready            (rx_ready),
        .o_inst_mem_addr       (inst_addr),
        .o_inst_mem_data       (inst_data),
        .o_inst_mem_we         (inst_we),
        .o_load_reg_addr       (reg_addr),
        .o_load_reg_data       (reg_data),
        .o_load_reg_we         (reg_we),
        .o_pc_instr_start_addr (start_pc),
        .o_setup               (setup),
        .o_inst_count          (inst_count),
        .o_err                 (err)
    );

    always #5 clk = ~clk;

    // kind: 0 instruction write, 1 register write, 2 start, 3 halt
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          cnt;
    } ev_t;

    ev_t          sb[$];
    logic [7:0]   pkt[$];
    int           checks = 0;
    int           passes = 0;
    int           m_cnt = 0;
    int           m_commits = 0;
    logic         m_err = 1'b0;
    logic [31:0]  m_pc = 32'h0;
    int           low_cycles = 0;
    logic         prev_setup = 1'b1;
    logic         prev_ready = 1'b1;
    logic         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic take(input int kind);
        ev_t e;
        if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_event: got event kind %0d expected none", kind);
            return;
        end
        e = sb.pop_front();
        chk("event_kind", 32'(kind), 32'(e.kind));
        case (kind)
            0: begin
                chk("inst_addr", inst_addr, e.addr);
                chk("inst_data", inst_data, e.data);
                chk("inst_count", 32'(inst_count), 32'(e.cnt));
                chk("inst_commit_ready", 32'(rx_ready), 32'd0);
            end
            1: begin
                chk("reg_addr", 32'(reg_addr), e.addr);
                chk("reg_data", reg_data, e.data);
                chk("reg_commit_ready", 32'(rx_ready), 32'd0);
            end
            2: begin
                chk("start_pc", start_pc, e.addr);
                chk("start_commit_ready", 32'(rx_ready), 32'd0);
            end
            default: begin
                chk("halt_pc_kept", start_pc, e.addr);
                chk("halt_ready", 32'(rx_ready), 32'd1);
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            if (!rx_ready) begin
                low_cycles++;
                chk("ready_low_single_cycle", 32'(prev_ready), 32'd1);
            end
            if (inst_we) take(0);
            if (reg_we) take(1);
            if (prev_setup && !setup) take(2);
            if (!prev_setup && setup) take(3);
        end
        prev_setup = setup;
        prev_ready = rx_ready;
    end

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && w < 8) begin
            @(negedge clk);
            w++;
        end
        if (w == 8) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int gaps);
        int r;
        if (gaps >= 0) return gaps;
        r = int'($urandom_range(0, 7));
        if (r == 0) return T - 1;
        if (r < 3) return int'($urandom_range(1, 3));
        return 0;
    endfunction

    task automatic send_pkt(input int gaps);
        for (int i = 0; i < pkt.size(); i++) begin
            if (i > 0) idle(pick_gap(gaps));
            send_byte(pkt[i]);
        end
    endtask

    task automatic add32(input logic [31:0] v);
        for (int i = 0; i < 4; i++) pkt.push_back(v[8*i +: 8]);
    endtask

    task automatic push_ev(input int kind, input logic [31:0] a, input logic [31:0] d, input int c);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        e.cnt  = c;
        sb.push_back(e);
    endtask

    task automatic do_inst(input logic [31:0] a, input logic [31:0] d, input int gaps);
        m_cnt = (m_cnt < SAT) ? m_cnt + 1 : SAT;
        m_commits++;
        push_ev(0, a, d, m_cnt);
        pkt.delete();
        pkt.push_back(8'h01);
        add32(a);
        add32(d);
        send_pkt(gaps);
    endtask

    task automatic do_reg(input logic [7:0] idx, input logic [31:0] d, input int gaps);
        m_commits++;
        if ((idx % 32) != 0) push_ev(1, 32'(idx % 32), d, 0);
        pkt.delete();
        pkt.push_back(8'h02);
        pkt.push_back(idx);
        add32(d);
        send_pkt(gaps);
    endtask

    task automatic do_start(input logic [31:0] pc, input int gaps);
        m_commits++;
        m_pc = pc;
        push_ev(2, pc, 32'h0, 0);
        pkt.delete();
        pkt.push_back(8'h03);
        add32(pc);
        send_pkt(gaps);
    endtask

    task automatic do_halt();
        push_ev(3, m_pc, 32'h0, 0);
        send_byte(8'h04);
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_err = 1'b0;
        m_pc  = 32'h0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(rx_ready), 32'd1);
        chk({tag, "_setup"}, 32'(setup), 32'd1);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_count"}, 32'(inst_count), 32'd0);
        chk({tag, "_strobes"}, {30'd0, inst_we, reg_we}, 32'd0);
        chk({tag, "_inst_addr"}, inst_addr, 32'd0);
        chk({tag, "_inst_data"}, inst_data, 32'd0);
        chk({tag, "_reg_addr"}, 32'(reg_addr), 32'd0);
        chk({tag, "_reg_data"}, reg_data, 32'd0);
        chk({tag, "_pc"}, start_pc, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        int          kind;
        int          nj;
        logic [7:0]  idx;
        logic [7:0]  b;
        logic [31:0] v;

        repeat (3) @(negedge clk);
        chk_reset_values("por");
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        do_inst(32'h0000_0004, 32'h0012_7413, 0);
        @(negedge clk);
        chk("count_after_first", 32'(inst_count), 32'd1);

        do_reg(8'h06, 32'h0000_0001, 0);
        do_reg(8'h00, 32'hFFFF_FFFF, 0);
        do_reg(8'hE3, 32'hDEAD_BEEF, 0);
        do_reg(8'h20, 32'h1234_5678, 0);
        @(negedge clk);
        chk("err_after_reg0", 32'(err), 32'(m_err));

        do_start(32'h0000_0004, 0);
        send_byte(8'hAA);
        send_byte(8'h01);
        idle(2);
        chk("setup_in_run", 32'(setup), 32'd0);
        chk("err_in_run", 32'(err), 32'd0);
        do_halt();
        chk("setup_after_halt", 32'(setup), 32'd1);

        pkt.delete();
        pkt.push_back(8'h01);
        pkt.push_back(8'h08);
        pkt.push_back(8'h00);
        send_pkt(0);
        idle(T - 1);
        chk("no_timeout_yet", 32'(err), 32'd0);
        idle(1);
        m_err = 1'b1;
        chk("timeout_err", 32'(err), 32'(m_err));
        do_inst($urandom, $urandom, 0);

        for (int i = 0; i < 16; i++) do_inst($urandom, $urandom, 0);
        @(negedge clk);
        chk("count_saturated", 32'(inst_count), 32'(m_cnt));

        for (int it = 0; it < 30; it++) begin
            kind = int'($urandom_range(0, 9));
            idle(int'($urandom_range(0, 2)));
            if (kind <= 3) begin
                do_inst($urandom, $urandom, -1);
            end else if (kind <= 6) begin
                idx = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 3) == 0) idx = idx & 8'hE0;
                do_reg(idx, $urandom, -1);
            end else if (kind == 7) begin
                do_start($urandom, -1);
                nj = int'($urandom_range(0, 3));
                for (int j = 0; j < nj; j++) begin
                    do b = 8'($urandom_range(0, 255)); while (b == 8'h04);
                    idle(int'($urandom_range(0, 3)));
                    send_byte(b);
                end
                do_halt();
            end else begin
                do b = 8'($urandom_range(0, 255)); while (b inside {8'h01, 8'h02, 8'h03});
                m_err = 1'b1;
                send_byte(b);
            end
        end
        @(negedge clk);
        chk("random_err", 32'(err), 32'(m_err));
        chk("random_count", 32'(inst_count), 32'(m_cnt));

        do_start(32'h8000_0100, 0);
        do_halt();
        pkt.delete();
        pkt.push_back(8'h01);
        add32(32'h0000_0040);
        pkt.push_back(8'h13);
        send_pkt(0);
        #2 rst = 1'b1;
        #1 chk_reset_values("midpkt");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        do_inst(32'h0000_0040, 32'h0000_0013, 0);
        @(negedge clk);
        chk("count_after_rst", 32'(inst_count), 32'd1);
        do_reg(8'h1F, $urandom, T - 1);
        @(negedge clk);
        chk("err_after_slow_pkt", 32'(err), 32'd0);
        m_err = 1'b1;
        send_byte(8'h7F);
        chk("err_unknown_cmd", 32'(err), 32'(m_err));

        v = $urandom;
        do_inst(32'h0000_0100, v, 0);
        chk("we_high_in_commit", 32'(inst_we), 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset_values("commit");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        do_reg(8'h05, $urandom, 0);

        idle(4);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("commit_cycles", 32'(low_cycles), 32'(m_commits));
        chk("final_err", 32'(err), 32'(m_err));
        chk("final_count", 32'(inst_count), 32'(m_cnt));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
